uart_cmd_slv: RTL

DUT-side end of the host command link: receives 24-bit commands from the host UART master as three 8N1 bytes and transmits 8-bit response bytes back. It sits between the `RX`/`TX` pins of `DSO_dig` and the command-dispatch state machine. It presents one assembled command with a ready/clear handshake and accepts one response byte at a time.

---
 rtl/dso_pkg.sv | 21 ++
 rtl/uart_cmd_slv_if.sv | 22 ++
 rtl/uart_tx_byte.sv | 78 +++++++
 rtl/uart_cmd_slv.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/dso_pkg.sv
// Shared DSO command-link definitions: opcodes, response codes and the
// UART receive/transmit state encodings.
package dso_pkg;

    localparam logic [7:0] CFG_GAIN    = 8'h02;
    localparam logic [7:0] TRIG_LVL    = 8'h03;
    localparam logic [7:0] TRIG_POS    = 8'h04;
    localparam logic [7:0] SET_DEC     = 8'h05;
    localparam logic [7:0] TRIG_CFG    = 8'h06;
    localparam logic [7:0] RD_TRIG_CFG = 8'h07;
    localparam logic [7:0] EEP_WRT     = 8'h08;
    localparam logic [7:0] EEP_RD      = 8'h09;
    localparam logic [7:0] DUMP_CH     = 8'h0A;

    localparam logic [7:0] ACK = 8'hA5;
    localparam logic [7:0] NAK = 8'hEE;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic       {TX_IDLE, TX_SHIFT}                   tx_state_t;

endpackage

// File: rtl/uart_cmd_slv_if.sv
// Command/response handshake between uart_cmd_slv (slave) and the
// command dispatcher (master).
interface uart_cmd_slv_if;
    logic [23:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic [7:0]  resp;
    logic        send_resp;
    logic        resp_sent;
    logic        tx_busy;
    logic        err;

    modport master (
        input  cmd, cmd_rdy, resp_sent, tx_busy, err,
        output clr_cmd_rdy, resp, send_resp
    );

    modport slave (
        output cmd, cmd_rdy, resp_sent, tx_busy, err,
        input  clr_cmd_rdy, resp, send_resp
    );
endinterface

// File: rtl/uart_tx_byte.sv
// 8N1 byte transmitter: shifts a {stop, data, start} frame out LSB first,
// one bit per BAUD_DIV clocks, pulsing done as the stop bit ends.
module uart_tx_byte
    import dso_pkg::*;
#(
    parameter int unsigned BAUD_DIV = 2604
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       send,
    input  logic [7:0] data,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    localparam int unsigned   CW      = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] FULL_M1 = CW'(BAUD_DIV - 1);

    tx_state_t     state, nxt;
    logic [CW-1:0] cnt;
    logic [3:0]    idx;
    logic [8:0]    shreg;
    logic          tick, last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= TX_IDLE;
        else        state <= nxt;
    end

    always_comb begin
        nxt  = state;
        tick = 1'b0;
        last = 1'b0;
        case (state)
            TX_IDLE:  if (send) nxt = TX_SHIFT;
            TX_SHIFT: if (cnt == FULL_M1) begin
                tick = 1'b1;
                if (idx == 4'd9) begin
                    last = 1'b1;
                    nxt  = TX_IDLE;
                end
            end
            default:  nxt = TX_IDLE;
        endcase
    end

    // The start bit is driven straight from the load; shreg holds the rest.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx    <= 1'b1;
            cnt   <= '0;
            idx   <= '0;
            shreg <= '1;
            done  <= 1'b0;
        end else begin
            done <= last;
            if (state == TX_IDLE) begin
                cnt <= '0;
                idx <= '0;
                if (send) begin
                    tx    <= 1'b0;
                    shreg <= {1'b1, data};
                end
            end else if (tick) begin
                cnt   <= '0;
                idx   <= idx + 4'd1;
                tx    <= shreg[0];
                shreg <= {1'b1, shreg[8:1]};
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign busy = (state == TX_SHIFT);

endmodule

// File: rtl/uart_cmd_slv.sv
// Host command link endpoint: assembles three 8N1 bytes into a 24-bit
// command with ready/clear handshake and transmits single response bytes.
module uart_cmd_slv
    import dso_pkg::*;
#(
    parameter int unsigned BAUD_DIV = 2604,
    parameter int unsigned GAP_BITS = 24
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           RX,
    output logic           TX,
    uart_cmd_slv_if.slave  cif
);

    localparam int unsigned   CW      = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] FULL_M1 = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(BAUD_DIV / 2 - 1);
    localparam int unsigned   GAP_CYC = GAP_BITS * BAUD_DIV;
    localparam int unsigned   GW      = $clog2(GAP_CYC);
    localparam logic [GW-1:0] GAP_M1  = GW'(GAP_CYC - 1);

    rx_state_t     rx_state, rx_nxt;
    logic          rx_s1, rx_s2, rx_s3;
    logic [CW-1:0] rx_cnt;
    logic [2:0]    rx_bit;
    logic [7:0]    rx_shift;
    logic          rx_tick, byte_done, frm_err;

    logic [1:0]    byte_cnt;
    logic [15:0]   hold;
    logic [GW-1:0] gap_cnt;
    logic          gap_to;
    logic [23:0]   cmd_q;
    logic          cmd_rdy_q, err_q;

    // rx_s3 only serves falling-edge detection on the synchronized line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) {rx_s1, rx_s2, rx_s3} <= 3'b111;
        else        {rx_s1, rx_s2, rx_s3} <= {RX, rx_s1, rx_s2};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rx_state <= RX_IDLE;
        else        rx_state <= rx_nxt;
    end

    always_comb begin
        rx_nxt    = rx_state;
        rx_tick   = 1'b0;
        byte_done = 1'b0;
        frm_err   = 1'b0;
        case (rx_state)
            RX_IDLE:  if (rx_s3 && !rx_s2) rx_nxt = RX_START;
            RX_START: if (rx_cnt == HALF_M1) begin
                rx_tick = 1'b1;
                rx_nxt  = rx_s2 ? RX_IDLE : RX_DATA;
            end
            RX_DATA:  if (rx_cnt == FULL_M1) begin
                rx_tick = 1'b1;
                if (rx_bit == 3'd7) rx_nxt = RX_STOP;
            end
            RX_STOP:  if (rx_cnt == FULL_M1) begin
                rx_tick   = 1'b1;
                rx_nxt    = RX_IDLE;
                byte_done = rx_s2;
                frm_err   = !rx_s2;
            end
            default:  rx_nxt = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
        end else begin
            if (rx_state == RX_IDLE || rx_tick) rx_cnt <= '0;
            else                                rx_cnt <= rx_cnt + 1'b1;
            if (rx_state == RX_START) begin
                rx_bit <= '0;
            end else if (rx_state == RX_DATA && rx_tick) begin
                rx_bit   <= rx_bit + 3'd1;
                rx_shift <= {rx_s2, rx_shift[7:1]};
            end
        end
    end

    assign gap_to = (byte_cnt != 2'd0) && (rx_state == RX_IDLE) && (gap_cnt == GAP_M1);

    // A clear coincident with a completing command loses to the new load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt  <= '0;
            hold      <= '0;
            gap_cnt   <= '0;
            cmd_q     <= '0;
            cmd_rdy_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            err_q <= 1'b0;
            if (byte_cnt == 2'd0 || rx_state != RX_IDLE || gap_to) gap_cnt <= '0;
            else                                                   gap_cnt <= gap_cnt + 1'b1;
            if (cif.clr_cmd_rdy) cmd_rdy_q <= 1'b0;
            if (frm_err || gap_to) begin
                byte_cnt <= '0;
                err_q    <= 1'b1;
            end else if (byte_done) begin
                case (byte_cnt)
                    2'd0: begin
                        hold[15:8] <= rx_shift;
                        byte_cnt   <= 2'd1;
                    end
                    2'd1: begin
                        hold[7:0] <= rx_shift;
                        byte_cnt  <= 2'd2;
                    end
                    default: begin
                        byte_cnt <= '0;
                        if (cmd_rdy_q && !cif.clr_cmd_rdy) begin
                            err_q <= 1'b1;
                        end else begin
                            cmd_q     <= {hold, rx_shift};
                            cmd_rdy_q <= 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    assign cif.cmd     = cmd_q;
    assign cif.cmd_rdy = cmd_rdy_q;
    assign cif.err     = err_q;

    uart_tx_byte #(.BAUD_DIV(BAUD_DIV)) u_tx (
        .clk   (clk),
        .rst_n (rst_n),
        .send  (cif.send_resp),
        .data  (cif.resp),
        .tx    (TX),
        .busy  (cif.tx_busy),
        .done  (cif.resp_sent)
    );

endmodule
